// File: rtl/ram_arbiter_pkg.sv
// Shared defines for the data-RAM arbiter: owner encoding used by the arbiter and its pick function.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_M0   = 2'd1,
        OWNER_M1   = 2'd2
    } owner_e;

endpackage

// File: rtl/arbiter_pick.sv
// Combinational next-owner function for a two-port arbiter with lock.
// ARBITER_ROUND_ROBIN_EN: ties go to the master that was not acked last; otherwise M0 wins ties.
module arbiter_pick
    import ram_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] lock,
    input  owner_e     owner,
`ifdef ARBITER_ROUND_ROBIN_EN
    input  logic       last_m1,
`endif
    output owner_e     next_owner
);

    always_comb begin
        next_owner = OWNER_NONE;
        if (owner == OWNER_M0 && req[0] && lock[0]) begin
            next_owner = OWNER_M0;
        end else if (owner == OWNER_M1 && req[1] && lock[1]) begin
            next_owner = OWNER_M1;
        end else begin
            case (req)
                2'b01:   next_owner = OWNER_M0;
                2'b10:   next_owner = OWNER_M1;
`ifdef ARBITER_ROUND_ROBIN_EN
                2'b11:   next_owner = last_m1 ? OWNER_M0 : OWNER_M1;
`else
                2'b11:   next_owner = OWNER_M0;
`endif
                default: next_owner = OWNER_NONE;
            endcase
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the data RAM between the CPU load/store port (M0) and the DMA/debug loader (M1).
// ARBITER_ROUND_ROBIN_EN selects round-robin tie-break; undefined gives fixed M0 priority.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter  int unsigned ADDR_WIDTH = 32,
    parameter  int unsigned DATA_WIDTH = 32,
    localparam int unsigned SEL_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  m0_req,
    input  logic                  m0_write,
    input  logic                  m0_lock,
    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic [SEL_WIDTH-1:0]  m0_select,
    input  logic [DATA_WIDTH-1:0] m0_write_data,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_read_data,

    input  logic                  m1_req,
    input  logic                  m1_write,
    input  logic                  m1_lock,
    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic [SEL_WIDTH-1:0]  m1_select,
    input  logic [DATA_WIDTH-1:0] m1_write_data,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_read_data,

    output logic                  ram_read_enable,
    output logic [ADDR_WIDTH-1:0] ram_read_address,
    input  logic [DATA_WIDTH-1:0] ram_read_data,
    output logic                  ram_write_enable,
    output logic [ADDR_WIDTH-1:0] ram_write_address,
    output logic [SEL_WIDTH-1:0]  ram_write_select,
    output logic [DATA_WIDTH-1:0] ram_write_data
);

    owner_e owner;
    owner_e owner_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner <= OWNER_NONE;
        end else begin
            owner <= owner_nxt;
        end
    end

    assign m0_ack = m0_req && (owner == OWNER_M0);
    assign m1_ack = m1_req && (owner == OWNER_M1);

`ifdef ARBITER_ROUND_ROBIN_EN
    // Tie-break sees this cycle's ack so back-to-back contention alternates every access.
    logic last_m1;
    logic last_eff;

    assign last_eff = m1_ack ? 1'b1 : (m0_ack ? 1'b0 : last_m1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_m1 <= 1'b1;
        end else begin
            last_m1 <= last_eff;
        end
    end
`endif

    arbiter_pick u_pick (
        .req        ({m1_req, m0_req}),
        .lock       ({m1_lock, m0_lock}),
        .owner      (owner),
`ifdef ARBITER_ROUND_ROBIN_EN
        .last_m1    (last_eff),
`endif
        .next_owner (owner_nxt)
    );

    // RAM port is driven by the owner only; everything is zero with no owner.
    always_comb begin
        ram_read_enable   = 1'b0;
        ram_write_enable  = 1'b0;
        ram_read_address  = '0;
        ram_write_address = '0;
        ram_write_select  = '0;
        ram_write_data    = '0;
        case (owner)
            OWNER_M0: begin
                ram_read_enable   = m0_ack && !m0_write;
                ram_write_enable  = m0_ack && m0_write;
                ram_read_address  = m0_address;
                ram_write_address = m0_address;
                ram_write_select  = m0_select;
                ram_write_data    = m0_write_data;
            end
            OWNER_M1: begin
                ram_read_enable   = m1_ack && !m1_write;
                ram_write_enable  = m1_ack && m1_write;
                ram_read_address  = m1_address;
                ram_write_address = m1_address;
                ram_write_select  = m1_select;
                ram_write_data    = m1_write_data;
            end
            default: ;
        endcase
    end

    assign m0_read_data = (owner == OWNER_M0) ? ram_read_data : '0;
    assign m1_read_data = (owner == OWNER_M1) ? ram_read_data : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small byte-lane RAM model behind the RAM port.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    logic        clock = 1'b0;
    logic        reset;

    logic        m0_req, m0_write, m0_lock, m0_ack;
    logic [31:0] m0_address, m0_write_data, m0_read_data;
    logic [3:0]  m0_select;
    logic        m1_req, m1_write, m1_lock, m1_ack;
    logic [31:0] m1_address, m1_write_data, m1_read_data;
    logic [3:0]  m1_select;

    logic        ram_read_enable, ram_write_enable;
    logic [31:0] ram_read_address, ram_write_address, ram_read_data, ram_write_data;
    logic [3:0]  ram_write_select;

    logic [31:0] mem [128];
    logic        pl_en;
    logic [31:0] pl_addr, pl_data;

    int n_cmp;
    int n_err;
    logic exp0;

    always #5 clock = ~clock;

    ram_arbiter dut (
        .clock             (clock),
        .reset             (reset),
        .m0_req            (m0_req),
        .m0_write          (m0_write),
        .m0_lock           (m0_lock),
        .m0_address        (m0_address),
        .m0_select         (m0_select),
        .m0_write_data     (m0_write_data),
        .m0_ack            (m0_ack),
        .m0_read_data      (m0_read_data),
        .m1_req            (m1_req),
        .m1_write          (m1_write),
        .m1_lock           (m1_lock),
        .m1_address        (m1_address),
        .m1_select         (m1_select),
        .m1_write_data     (m1_write_data),
        .m1_ack            (m1_ack),
        .m1_read_data      (m1_read_data),
        .ram_read_enable   (ram_read_enable),
        .ram_read_address  (ram_read_address),
        .ram_read_data     (ram_read_data),
        .ram_write_enable  (ram_write_enable),
        .ram_write_address (ram_write_address),
        .ram_write_select  (ram_write_select),
        .ram_write_data    (ram_write_data)
    );

    // RAM model: combinational read, byte-lane write at the clock edge, plus a bench preload port.
    assign ram_read_data = mem[ram_read_address[8:2]];

    always @(posedge clock) begin
        if (pl_en) begin
            mem[pl_addr[8:2]] <= pl_data;
        end else if (ram_write_enable) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_write_select[b]) mem[ram_write_address[8:2]][8*b +: 8] <= ram_write_data[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_masters();
        m0_req = 1'b0; m0_write = 1'b0; m0_lock = 1'b0;
        m0_address = '0; m0_select = '0; m0_write_data = '0;
        m1_req = 1'b0; m1_write = 1'b0; m1_lock = 1'b0;
        m1_address = '0; m1_select = '0; m1_write_data = '0;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        pl_en = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        reset = 1'b1;
        idle_masters();
        tick();
        check("rst_owner", 64'(dut.owner), 64'(OWNER_NONE));
        check("rst_we", 64'(ram_write_enable), 64'(0));
        preload(32'h10, 32'hDEADBEEF);
        preload(32'h20, 32'h12345678);
        preload(32'h30, 32'h55555555);
        reset = 1'b0;

        // Reset release, M0 single read of 0x10.
        m0_req = 1'b1; m0_address = 32'h10;
        settle();
        check("rd_c1_ack0", 64'(m0_ack), 64'(0));
        tick();
        check("rd_c2_ack0", 64'(m0_ack), 64'(1));
        check("rd_c2_ack1", 64'(m1_ack), 64'(0));
        check("rd_c2_re", 64'(ram_read_enable), 64'(1));
        check("rd_c2_data", 64'(m0_read_data), 64'(32'hDEADBEEF));
        check("rd_c2_m1data", 64'(m1_read_data), 64'(0));
        idle_masters();
        settle();
        check("rd_drop_ack", 64'(m0_ack), 64'(0));

        // Both masters writing continuously without lock.
        reset_pulse();
        m0_req = 1'b1; m0_write = 1'b1; m0_select = 4'hF; m0_address = 32'h40; m0_write_data = 32'h11111111;
        m1_req = 1'b1; m1_write = 1'b1; m1_select = 4'hF; m1_address = 32'h80; m1_write_data = 32'h22222222;
        settle();
        check("cont_c0_ack0", 64'(m0_ack), 64'(0));
        check("cont_c0_ack1", 64'(m1_ack), 64'(0));
        for (int i = 0; i < 8; i++) begin
            tick();
`ifdef ARBITER_ROUND_ROBIN_EN
            exp0 = (i % 2 == 0);
`else
            exp0 = 1'b1;
`endif
            check($sformatf("cont_ack0_%0d", i), 64'(m0_ack), 64'(exp0));
            check($sformatf("cont_ack1_%0d", i), 64'(m1_ack), 64'(!exp0));
            check($sformatf("cont_wa_%0d", i), 64'(ram_write_address), exp0 ? 64'(32'h40) : 64'(32'h80));
        end
        idle_masters();

        // Locked 4-beat M1 burst with M0 waiting.
        reset_pulse();
        m1_req = 1'b1; m1_lock = 1'b1; m1_write = 1'b1; m1_select = 4'hF;
        m1_address = 32'h100; m1_write_data = 32'hB0000000;
        settle();
        check("burst_c0_ack1", 64'(m1_ack), 64'(0));
        tick();
        m0_req = 1'b1; m0_address = 32'h10;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("burst_ack1_%0d", i), 64'(m1_ack), 64'(1));
            check($sformatf("burst_ack0_%0d", i), 64'(m0_ack), 64'(0));
            check($sformatf("burst_wa_%0d", i), 64'(ram_write_address), 64'(32'h100 + 32'(4 * i)));
            tick();
            m1_address = 32'h100 + 32'(4 * (i + 1));
            m1_write_data = 32'hB0000000 + 32'(i + 1);
        end
        m1_req = 1'b0;
        settle();
        check("burst_rel_ack1", 64'(m1_ack), 64'(0));
        check("burst_rel_ack0", 64'(m0_ack), 64'(0));
        tick();
        check("burst_m0_ack", 64'(m0_ack), 64'(1));
        check("burst_m0_data", 64'(m0_read_data), 64'(32'hDEADBEEF));
        idle_masters();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("burst_mem_%0d", i), 64'(mem[64 + i]), 64'(32'hB0000000 + 32'(i)));
        end

        // Byte-lane write then read back.
        reset_pulse();
        m0_req = 1'b1; m0_write = 1'b1; m0_select = 4'b0010; m0_address = 32'h20; m0_write_data = 32'h0000AB00;
        settle();
        tick();
        check("byte_ack", 64'(m0_ack), 64'(1));
        check("byte_we", 64'(ram_write_enable), 64'(1));
        check("byte_sel", 64'(ram_write_select), 64'(4'b0010));
        tick();
        m0_write = 1'b0; m0_select = '0; m0_write_data = '0;
        settle();
        check("byte_rd_ack", 64'(m0_ack), 64'(1));
        check("byte_rd_data", 64'(m0_read_data), 64'(32'h1234AB78));
        idle_masters();

        // Reset during an M1 write ack cycle.
        reset_pulse();
        m1_req = 1'b1; m1_write = 1'b1; m1_select = 4'hF; m1_address = 32'h30; m1_write_data = 32'hCAFEF00D;
        settle();
        tick();
        check("rstw_we_before", 64'(ram_write_enable), 64'(1));
        reset = 1'b1;
        settle();
        check("rstw_we", 64'(ram_write_enable), 64'(0));
        check("rstw_ack1", 64'(m1_ack), 64'(0));
        check("rstw_wa", 64'(ram_write_address), 64'(0));
        tick();
        check("rstw_mem", 64'(mem[12]), 64'(32'h55555555));
        idle_masters();
        reset = 1'b0;
        settle();
        check("rstw_owner", 64'(dut.owner), 64'(OWNER_NONE));

        // Idle: nothing driven, owner stays NONE.
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("idle_owner_%0d", i), 64'(dut.owner), 64'(OWNER_NONE));
            check($sformatf("idle_en_%0d", i), 64'({ram_read_enable, ram_write_enable, m0_ack, m1_ack}), 64'(0));
            check($sformatf("idle_addr_%0d", i), 64'({ram_read_address, ram_write_address}), 64'(0));
            check($sformatf("idle_wd_%0d", i), 64'({ram_write_select, ram_write_data}), 64'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
